// File: rtl/rmgmt_mul_branch_ext.sv
// RISC-MGMT example extension: iterative unsigned multiplier (MUL / MULHU)
// plus a single-cycle compare-equal branch (BEQX) and an illegal-op trap.
//
// Handshake: the core holds start high for as long as busy is high. The
// extension drops busy in the cycle it asserts reg_w (DONE), which is when
// the pipeline advances. A branch or illegal op never raises busy. flush
// overrides everything and drops the instruction in the cycle it is seen.
//
// The cycle after nRST is released is treated as quiet. All outputs stay 0
// and start is not accepted, so nothing issues while the pipeline refills.
//
// BITS_PER_CYCLE must be 1, 2, 4 or 8 so that it divides 32 exactly.
module rmgmt_mul_branch_ext #(
    parameter  int BITS_PER_CYCLE = 1,
    localparam int N_ITER         = 32 / BITS_PER_CYCLE,
    localparam int CNT_W          = 6
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [12:0] imm,
    input  logic        flush,
    input  logic [31:0] rdata_s_0,
    input  logic [31:0] rdata_s_1,
    input  logic [31:0] pc,
    output logic        exception,
    output logic        busy,
    output logic        reg_w,
    output logic [31:0] reg_wdata,
    output logic        branch_jump,
    output logic [31:0] br_j_addr,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_BEQX  = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    state_t             state;
    state_t             state_next;
    logic               active;
    logic [63:0]        acc;
    logic [63:0]        mcand;
    logic [31:0]        mplier;
    logic [CNT_W-1:0]   cnt;
    logic               op_hi;
    logic               load;
    logic               step;
    logic [63:0]        partial;
    logic [31:0]        br_offset;
    logic               unused_imm0;

    // Byte offset bit 0 is not part of the target; keep it visibly consumed.
    assign unused_imm0 = imm[0];

    assign dbg_state = state;

    // Goes high one clock after reset release and stays high.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and all control outputs; flush and the quiet cycle win.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        reg_w       = 1'b0;
        exception   = 1'b0;
        branch_jump = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        if (!active) begin
            state_next = S_IDLE;
        end else if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MUL, OP_MULHU: begin
                                load       = 1'b1;
                                busy       = 1'b1;
                                state_next = S_MUL;
                            end
                            OP_BEQX: begin
                                branch_jump = (rdata_s_0 == rdata_s_1);
                            end
                            OP_ILL: begin
                                exception = 1'b1;
                            end
                            default: begin
                                exception = 1'b0;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    busy = 1'b1;
                    step = 1'b1;
                    // Last iteration retires the final multiplier bits.
                    if (cnt == CNT_W'(1)) begin
                        state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    reg_w      = 1'b1;
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Partial product of the multiplicand and the low multiplier bits,
    // built as a shift-add so the width stays a plain 64-bit adder chain.
    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
    end

    // Multiplier datapath: load operands on issue, accumulate per iteration.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            op_hi  <= 1'b0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {32'b0, rdata_s_0};
            mplier <= rdata_s_1;
            cnt    <= CNT_W'(N_ITER);
            op_hi  <= (op == OP_MULHU);
        end else if (step) begin
            acc    <= acc + partial;
            mcand  <= mcand << BITS_PER_CYCLE;
            mplier <= mplier >> BITS_PER_CYCLE;
            cnt    <= cnt - CNT_W'(1);
        end
    end

    // Result half selected from the held accumulator; meaningful under reg_w.
    assign reg_wdata = op_hi ? acc[63:32] : acc[31:0];

    // Branch target: pc plus the sign-extended halfword-aligned offset.
    assign br_offset = {{19{imm[12]}}, imm[12:1], 1'b0};
    assign br_j_addr = active ? (pc + br_offset) : 32'd0;

endmodule

// File: tb/tb_rmgmt_mul_branch_ext.sv
// Bench for rmgmt_mul_branch_ext: one instance per multiplier width
// (1 and 4 bits per cycle), a writeback scoreboard per instance, and a
// reference model using plain 64-bit arithmetic.
module tb_rmgmt_mul_branch_ext;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } wb_t;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [12:0] imm = '0;
  logic        flush = 1'b0;
  logic [31:0] rs0 = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] pc = '0;

  logic        exc1, busy1, regw1, bj1;
  logic [31:0] wdata1, bja1;
  logic [1:0]  dbg1;
  logic        exc4, busy4, regw4, bj4;
  logic [31:0] wdata4, bja4;
  logic [1:0]  dbg4;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  wb_t exp_q1[$];
  wb_t exp_q4[$];

  // clock / cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  rmgmt_mul_branch_ext #(.BITS_PER_CYCLE(1)) dut1 (
    .CLK(CLK), .nRST(nRST), .start(start1), .op(op), .imm(imm), .flush(flush),
    .rdata_s_0(rs0), .rdata_s_1(rs1), .pc(pc),
    .exception(exc1), .busy(busy1), .reg_w(regw1), .reg_wdata(wdata1),
    .branch_jump(bj1), .br_j_addr(bja1), .dbg_state(dbg1)
  );

  rmgmt_mul_branch_ext #(.BITS_PER_CYCLE(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .start(start4), .op(op), .imm(imm), .flush(flush),
    .rdata_s_0(rs0), .rdata_s_1(rs1), .pc(pc),
    .exception(exc4), .busy(busy4), .reg_w(regw4), .reg_wdata(wdata4),
    .branch_jump(bj4), .br_j_addr(bja4), .dbg_state(dbg4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    return o[0] ? p[63:32] : p[31:0];
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] p, input logic [12:0] im);
    int v;
    v = int'(im);
    if (v >= 4096) v = v - 8192;
    v = v - (v & 1);
    return p + 32'(v);
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 3))
      0: return $urandom();
      1: return 32'($urandom_range(0, 255));
      2: return 32'hFFFF_FFFF;
      default: return 32'($urandom_range(0, 1)) << $urandom_range(0, 31);
    endcase
  endfunction

  // monitors: every writeback must match the head of the expected queue
  always @(negedge CLK) begin
    if (regw1 !== 1'b0) begin
      if (exp_q1.size() == 0) begin
        chk("wb1_unexpected", {63'b0, regw1}, 64'd0);
      end else begin
        wb_t e;
        e = exp_q1.pop_front();
        chk("wb1_data", {32'b0, wdata1}, {32'b0, e.data});
        chk("wb1_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge CLK) begin
    if (regw4 !== 1'b0) begin
      if (exp_q4.size() == 0) begin
        chk("wb4_unexpected", {63'b0, regw4}, 64'd0);
      end else begin
        wb_t e;
        e = exp_q4.pop_front();
        chk("wb4_data", {32'b0, wdata4}, {32'b0, e.data});
        chk("wb4_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_start(input bit sel4, input logic v);
    if (sel4) start4 = v;
    else start1 = v;
  endtask

  // Issue MUL/MULHU; flush_at < 0 means no flush, else the relative cycle.
  task automatic mul_op(input bit sel4, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int flush_at);
    int n;
    int c0;
    wb_t e;
    bit flushed;
    n = sel4 ? 8 : 32;
    c0 = cyc;
    flushed = 1'b0;
    if (flush_at < 0) begin
      e.data = ref_mul(o, a, b);
      e.cyc = c0 + n + 1;
      if (sel4) exp_q4.push_back(e);
      else exp_q1.push_back(e);
    end
    op = o;
    rs0 = a;
    rs1 = b;
    set_start(sel4, 1'b1);
    for (int k = 0; k <= n + 1; k++) begin
      if (k == flush_at) begin
        flush = 1'b1;
        set_start(sel4, 1'b0);
        flushed = 1'b1;
      end
      @(negedge CLK);
      chk(sel4 ? "busy4" : "busy1", {63'b0, sel4 ? busy4 : busy1},
          {63'b0, (!flushed && k <= n)});
      next_cycle();
      flush = 1'b0;
      if (flushed) break;
    end
    set_start(sel4, 1'b0);
    if (flushed) begin
      @(negedge CLK);
      chk(sel4 ? "busy4_after_flush" : "busy1_after_flush", {63'b0, sel4 ? busy4 : busy1}, 64'd0);
      next_cycle();
    end
  endtask

  task automatic br_op(input bit sel4, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [12:0] im, input logic fl);
    logic taken;
    op = 2'b10;
    rs0 = a;
    rs1 = b;
    pc = p;
    imm = im;
    flush = fl;
    set_start(sel4, 1'b1);
    taken = !fl && (a == b);
    @(negedge CLK);
    chk("br_taken", {63'b0, sel4 ? bj4 : bj1}, {63'b0, taken});
    chk("br_busy", {63'b0, sel4 ? busy4 : busy1}, 64'd0);
    chk("br_exc", {63'b0, sel4 ? exc4 : exc1}, 64'd0);
    if (taken) chk("br_addr", {32'b0, sel4 ? bja4 : bja1}, {32'b0, ref_target(p, im)});
    next_cycle();
    set_start(sel4, 1'b0);
    flush = 1'b0;
  endtask

  task automatic ill_op(input bit sel4);
    op = 2'b11;
    set_start(sel4, 1'b1);
    @(negedge CLK);
    chk("ill_exc", {63'b0, sel4 ? exc4 : exc1}, 64'd1);
    chk("ill_busy", {63'b0, sel4 ? busy4 : busy1}, 64'd0);
    next_cycle();
    set_start(sel4, 1'b0);
    @(negedge CLK);
    chk("ill_exc_one_cycle", {63'b0, sel4 ? exc4 : exc1}, 64'd0);
    chk("idle_bj", {63'b0, sel4 ? bj4 : bj1}, 64'd0);
    next_cycle();
  endtask

  task automatic chk_all_zero(input string name, input bit sel4);
    if (sel4) begin
      chk({name, "_4"}, {exc4, busy4, regw4, bj4, dbg4, 26'b0, wdata4 | bja4}, 64'd0);
    end else begin
      chk({name, "_1"}, {exc1, busy1, regw1, bj1, dbg1, 26'b0, wdata1 | bja1}, 64'd0);
    end
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [12:0] im;
    // reset with a branch already presented: everything stays 0
    start1 = 1'b1;
    op = 2'b10;
    rs0 = 32'h5;
    rs1 = 32'h5;
    pc = 32'h0000_0100;
    imm = 13'h1FF8;
    repeat (3) next_cycle();
    @(negedge CLK);
    chk_all_zero("in_reset", 1'b0);
    chk_all_zero("in_reset", 1'b1);
    next_cycle();
    nRST = 1'b1;
    @(negedge CLK);
    chk_all_zero("first_after_release", 1'b0);
    next_cycle();
    @(negedge CLK);
    chk("br_after_release", {63'b0, bj1}, 64'd1);
    chk("br_after_release_addr", {32'b0, bja1}, 64'h0000_00F8);
    next_cycle();
    start1 = 1'b0;
    next_cycle();

    // directed multiplies
    mul_op(1'b0, 2'b00, 32'd7, 32'd6, -1);
    mul_op(1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    mul_op(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    mul_op(1'b1, 2'b00, 32'h1234_5678, 32'h10, -1);
    mul_op(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);

    // directed branches and illegal op
    br_op(1'b0, 32'h5, 32'h5, 32'h0000_0100, 13'h1FF8, 1'b0);
    br_op(1'b0, 32'h5, 32'h6, 32'h0000_0100, 13'h1FF8, 1'b0);
    br_op(1'b0, 32'h9, 32'h9, 32'hFFFF_FFFC, 13'd8, 1'b0);
    br_op(1'b1, 32'h9, 32'h9, 32'h0000_0040, 13'h0FFF, 1'b0);
    br_op(1'b0, 32'h9, 32'h9, 32'h0000_0040, 13'd16, 1'b1);
    ill_op(1'b0);
    ill_op(1'b1);

    // flush mid-multiply, then a fresh multiply two cycles after the flush
    mul_op(1'b0, 2'b00, 32'hDEAD_BEEF, 32'h1234_5678, 10);
    mul_op(1'b0, 2'b00, 32'd3, 32'd3, -1);
    // flush in the result cycle suppresses the writeback
    mul_op(1'b0, 2'b01, 32'hFFFF_0000, 32'h0001_FFFF, 33);
    mul_op(1'b1, 2'b00, 32'h0000_00FF, 32'h0000_0101, 9);
    mul_op(1'b1, 2'b00, 32'h0000_1000, 32'h0000_0003, 3);

    // reset in the middle of a 4-bit-per-cycle multiply
    op = 2'b00;
    rs0 = 32'hCAFE_F00D;
    rs1 = 32'h0BAD_CAFE;
    start4 = 1'b1;
    repeat (4) next_cycle();
    nRST = 1'b0;
    start4 = 1'b0;
    @(negedge CLK);
    chk_all_zero("reset_mid_op", 1'b1);
    next_cycle();
    nRST = 1'b1;
    repeat (15) next_cycle();

    // randomized multiplies on both widths and random branches
    for (int i = 0; i < 10; i++) begin
      a = pick_operand();
      b = pick_operand();
      mul_op(i[0], 2'($urandom_range(0, 1)), a, b, -1);
    end
    for (int i = 0; i < 12; i++) begin
      a = $urandom();
      b = ($urandom_range(0, 1) == 1) ? a : $urandom();
      im = 13'($urandom());
      br_op(i[0], a, b, $urandom(), im, 1'b0);
    end

    repeat (5) next_cycle();
    chk("q1_drained", 64'(exp_q1.size()), 64'd0);
    chk("q4_drained", 64'(exp_q4.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
